// File: rtl/coeff_bank_if.sv
// coeff_bank_if
// Groups the host register port, frame sync, dual-port BRAM ports and the
// coefficient-file shadow port of coeff_bank_ctrl.
//   slave  : controller view (drives busy/err, BRAM addresses, shadow writes)
//   master : environment view (host, BRAM, sync source)
interface coeff_bank_if #(
  parameter int BANK_AW = 5,
  parameter int WIDTH   = 32
);
  logic               host_we;
  logic [BANK_AW-1:0] host_addr;
  logic [WIDTH-1:0]   host_din;
  logic               host_commit;
  logic               host_busy;
  logic               host_err;
  logic               vs_i;
  logic               bram_we_a;
  logic [BANK_AW:0]   bram_addr_a;
  logic [WIDTH-1:0]   bram_din_a;
  logic [BANK_AW:0]   bram_addr_b;
  logic [WIDTH-1:0]   bram_dout_b;
  logic               coeff_we;
  logic [BANK_AW-1:0] coeff_idx;
  logic [15:0]        coeff_data;
  logic               coeff_swap;
  logic               active_bank;
  logic               coeff_valid;

  modport slave (
    input  host_we, host_addr, host_din, host_commit, vs_i, bram_dout_b,
    output host_busy, host_err, bram_we_a, bram_addr_a, bram_din_a,
           bram_addr_b, coeff_we, coeff_idx, coeff_data, coeff_swap,
           active_bank, coeff_valid
  );

  modport master (
    output host_we, host_addr, host_din, host_commit, vs_i, bram_dout_b,
    input  host_busy, host_err, bram_we_a, bram_addr_a, bram_din_a,
           bram_addr_b, coeff_we, coeff_idx, coeff_data, coeff_swap,
           active_bank, coeff_valid
  );
endinterface

// File: rtl/coeff_bank_ctrl.sv
// coeff_bank_ctrl
// Double-buffered loader for the 5x5 FIR coefficient BRAM. Host writes land in
// the inactive bank through port A; a commit arms a load that starts on the
// next vs_i rising edge, streams the 25 words through port B into the
// coefficient shadow file, and ends with a one-cycle swap pulse.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : coeff_bank_if.slave (host, sync, BRAM A/B, shadow write port)
//
// state   | meaning
// IDLE    | accepting host writes and commits
// PENDING | commit armed, waiting for a vs_i rising edge
// READ    | issuing port B reads, rd_cnt = word being addressed
// DRAIN   | last read data returning from the BRAM
// SWAP    | coeff_swap asserted, bank flips at the end of this cycle
module coeff_bank_ctrl #(
  parameter int NCOEFF  = 25,
  parameter int BANK_AW = 5,
  parameter int WIDTH   = 32
) (
  input logic         clk,
  input logic         rst,
  coeff_bank_if.slave bus
);

  typedef enum logic [2:0] {IDLE, PENDING, READ, DRAIN, SWAP} state_t;

  localparam logic [BANK_AW-1:0] LAST_IDX = BANK_AW'(NCOEFF - 1);

  state_t             state;
  logic [BANK_AW-1:0] rd_cnt;
  logic               vs_q;
  logic               host_busy;
  logic               host_err;
  logic               bram_we_a;
  logic [BANK_AW:0]   bram_addr_a;
  logic [WIDTH-1:0]   bram_din_a;
  logic [BANK_AW:0]   bram_addr_b;
  logic               coeff_we;
  logic [BANK_AW-1:0] coeff_idx;
  logic               coeff_swap;
  logic               active_bank;
  logic               coeff_valid;

  logic vs_rise;
  logic wr_ok;
  logic unused_dout_hi;

  assign vs_rise = bus.vs_i & ~vs_q;
  assign wr_ok   = bus.host_we & ~host_busy & (bus.host_addr <= LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      vs_q        <= 1'b0;
      host_busy   <= 1'b0;
      host_err    <= 1'b0;
      bram_we_a   <= 1'b0;
      bram_addr_a <= '0;
      bram_din_a  <= '0;
      bram_addr_b <= '0;
      coeff_we    <= 1'b0;
      coeff_idx   <= '0;
      coeff_swap  <= 1'b0;
      active_bank <= 1'b0;
      coeff_valid <= 1'b0;
    end else begin
      vs_q       <= bus.vs_i;
      bram_we_a  <= 1'b0;
      host_err   <= 1'b0;
      coeff_we   <= 1'b0;
      coeff_swap <= 1'b0;

      // Host port A: only the inactive bank is ever written.
      if (wr_ok) begin
        bram_we_a   <= 1'b1;
        bram_addr_a <= {~active_bank, bus.host_addr};
        bram_din_a  <= bus.host_din;
      end
      if ((bus.host_we && !wr_ok) || (bus.host_commit && host_busy))
        host_err <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.host_commit) begin
            state     <= PENDING;
            host_busy <= 1'b1;
          end
        end
        PENDING: begin
          // vs_q already reflects a high vs_i from the commit cycle, so an
          // edge coinciding with the commit never starts the load.
          if (vs_rise) begin
            state       <= READ;
            rd_cnt      <= '0;
            bram_addr_b <= {~active_bank, {BANK_AW{1'b0}}};
          end
        end
        READ: begin
          // Strobe and index trail the address by one cycle to line up with
          // the BRAM read latency.
          coeff_we  <= 1'b1;
          coeff_idx <= rd_cnt;
          if (rd_cnt == LAST_IDX) begin
            state <= DRAIN;
          end else begin
            rd_cnt      <= rd_cnt + 1'b1;
            bram_addr_b <= {~active_bank, rd_cnt + 1'b1};
          end
        end
        DRAIN: begin
          state      <= SWAP;
          coeff_swap <= 1'b1;
        end
        SWAP: begin
          state       <= IDLE;
          rd_cnt      <= '0;
          active_bank <= ~active_bank;
          coeff_valid <= 1'b1;
          host_busy   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign unused_dout_hi = ^bus.bram_dout_b[WIDTH-1:16];

  assign bus.host_busy   = host_busy;
  assign bus.host_err    = host_err;
  assign bus.bram_we_a   = bram_we_a;
  assign bus.bram_addr_a = bram_addr_a;
  assign bus.bram_din_a  = bram_din_a;
  assign bus.bram_addr_b = bram_addr_b;
  assign bus.coeff_we    = coeff_we;
  assign bus.coeff_idx   = coeff_idx;
  assign bus.coeff_data  = bus.bram_dout_b[15:0];
  assign bus.coeff_swap  = coeff_swap;
  assign bus.active_bank = active_bank;
  assign bus.coeff_valid = coeff_valid;

endmodule

// File: tb/tb_coeff_bank_ctrl.sv
// tb_coeff_bank_ctrl
// Drives coeff_bank_ctrl with directed and randomized host traffic and frame
// syncs, models the dual-port BRAM, and checks shadow writes and swaps
// against a bank-level reference model through a scoreboard queue.
module tb_coeff_bank_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coeff_bank_if bus ();

  coeff_bank_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // dual-port BRAM stand-in, 1-cycle read latency on port B
  logic [31:0] bram [64];
  always @(posedge clk)
    if (bus.bram_we_a) bram[bus.bram_addr_a] <= bus.bram_din_a;
  always @(posedge clk or posedge rst)
    if (rst) bus.bram_dout_b <= '0;
    else     bus.bram_dout_b <= bram[bus.bram_addr_b];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: bank contents, active bank, busy/valid flags
  logic [31:0] model_mem [2][25];
  bit ab_m, valid_m, busy_m;

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;
  exp_t load_q[$];
  int   swap_q[$];
  int   swaps_seen = 0;
  exp_t mon_e;
  int   mon_s;

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.coeff_we) begin
        if (load_q.size() == 0) begin
          chk(1'b0, "unexpected_coeff_we", 64'(bus.coeff_idx), 64'd0);
        end else begin
          mon_e = load_q.pop_front();
          chk(bus.coeff_idx == mon_e.idx[4:0], "coeff_idx", 64'(bus.coeff_idx), 64'(mon_e.idx));
          chk(bus.coeff_data == mon_e.data, "coeff_data", 64'(bus.coeff_data), 64'(mon_e.data));
        end
      end
      if (bus.coeff_swap) begin
        swaps_seen++;
        if (swap_q.size() == 0) begin
          chk(1'b0, "unexpected_swap", 64'(cyc), 64'd0);
        end else begin
          mon_s = swap_q.pop_front();
          chk(cyc == mon_s, "swap_cycle", 64'(cyc), 64'(mon_s));
          chk(load_q.size() == 0, "words_before_swap", 64'(load_q.size()), 64'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk(bus.host_busy == 0 && bus.host_err == 0, {tag, "_host"}, {bus.host_busy, bus.host_err}, 0);
    chk(bus.bram_we_a == 0 && bus.bram_addr_a == 0 && bus.bram_din_a == 0,
        {tag, "_port_a"}, {bus.bram_we_a, bus.bram_addr_a, bus.bram_din_a}, 0);
    chk(bus.bram_addr_b == 0, {tag, "_addr_b"}, 64'(bus.bram_addr_b), 0);
    chk(bus.coeff_we == 0 && bus.coeff_idx == 0 && bus.coeff_swap == 0,
        {tag, "_coeff"}, {bus.coeff_we, bus.coeff_idx, bus.coeff_swap}, 0);
    chk(bus.coeff_data == 0, {tag, "_coeff_data"}, 64'(bus.coeff_data), 0);
    chk(bus.active_bank == 0 && bus.coeff_valid == 0, {tag, "_bank"},
        {bus.active_bank, bus.coeff_valid}, 0);
  endtask

  // one host write, optionally with a commit in the same cycle
  task automatic do_write(input int idx, input logic [31:0] d, input bit with_commit);
    bit          acc;
    bit          exp_err;
    logic [5:0]  exp_addr;
    int          wb;
    acc      = !busy_m && idx < 25;
    exp_err  = !acc || (with_commit && busy_m);
    wb       = ab_m ? 0 : 1;
    exp_addr = {~ab_m, 5'(idx)};
    bus.host_we     = 1'b1;
    bus.host_addr   = 5'(idx);
    bus.host_din    = d;
    bus.host_commit = with_commit;
    tick();
    bus.host_we     = 1'b0;
    bus.host_commit = 1'b0;
    chk(bus.bram_we_a == acc, "bram_we_a", 64'(bus.bram_we_a), 64'(acc));
    if (acc) begin
      chk(bus.bram_addr_a == exp_addr, "bram_addr_a", 64'(bus.bram_addr_a), 64'(exp_addr));
      chk(bus.bram_din_a == d, "bram_din_a", 64'(bus.bram_din_a), 64'(d));
      model_mem[wb][idx] = d;
    end
    chk(bus.host_err == exp_err, "host_err_write", 64'(bus.host_err), 64'(exp_err));
    if (with_commit && !busy_m) busy_m = 1'b1;
    chk(bus.host_busy == busy_m, "host_busy_write", 64'(bus.host_busy), 64'(busy_m));
  endtask

  task automatic do_commit(input bit vs_too);
    bit exp_err;
    exp_err = busy_m;
    bus.host_commit = 1'b1;
    if (vs_too) bus.vs_i = 1'b1;
    tick();
    bus.host_commit = 1'b0;
    chk(bus.host_err == exp_err, "host_err_commit", 64'(bus.host_err), 64'(exp_err));
    busy_m = 1'b1;
    chk(bus.host_busy == 1'b1, "host_busy_commit", 64'(bus.host_busy), 64'd1);
  endtask

  // raise vs_i with a commit pending and follow the load to its swap
  task automatic frame(input bit toggle);
    int   v, rb, n, target;
    exp_t e;
    v  = cyc;
    rb = ab_m ? 0 : 1;
    bus.vs_i = 1'b1;
    for (int i = 0; i < 25; i++) begin
      e.idx  = i;
      e.data = model_mem[rb][i][15:0];
      load_q.push_back(e);
    end
    swap_q.push_back(v + 27);
    target = swaps_seen + 1;
    n = 0;
    while (swaps_seen < target && n < 40) begin
      tick();
      n++;
      if (toggle) bus.vs_i = 1'($urandom_range(0, 1));
      else if (n == 3) bus.vs_i = 1'b0;
      if (n < 27) chk(bus.host_busy == 1'b1, "host_busy_load", 64'(bus.host_busy), 64'd1);
    end
    bus.vs_i = 1'b0;
    chk(swaps_seen == target, "swap_timeout", 64'(swaps_seen), 64'(target));
    ab_m    = ~ab_m;
    valid_m = 1'b1;
    busy_m  = 1'b0;
    chk(bus.active_bank == ab_m, "active_bank", 64'(bus.active_bank), 64'(ab_m));
    chk(bus.coeff_valid == valid_m, "coeff_valid", 64'(bus.coeff_valid), 64'(valid_m));
    chk(bus.host_busy == 1'b0, "host_busy_after", 64'(bus.host_busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, nw, idx, gap;
    bit wc;
    for (int i = 0; i < 64; i++) bram[i] = '0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 25; i++) model_mem[b][i] = '0;
    bus.host_we = 0; bus.host_addr = '0; bus.host_din = '0;
    bus.host_commit = 0; bus.vs_i = 0;
    ab_m = 0; valid_m = 0; busy_m = 0;

    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk) rst = 1'b0;
    tick();

    // write then commit: bank 1 gets 0x100+idx
    for (int i = 0; i < 25; i++) do_write(i, 32'h0000_0100 + 32'(i), 1'b0);
    do_commit(1'b0);
    tick();
    frame(1'b0);

    // second cycle: negative coefficient into bank 0
    do_write(3, 32'hFFFF_FF80, 1'b0);
    do_commit(1'b0);
    frame(1'b0);

    // rejects: out-of-range address, write and commit while pending
    do_write(27, 32'h1234_5678, 1'b0);
    do_commit(1'b0);
    do_write(5, 32'hDEAD_BEEF, 1'b0);
    do_commit(1'b0);
    tick();
    frame(1'b0);

    // vs_i rising in the commit cycle does not start the load
    do_commit(1'b1);
    repeat (5) tick();
    chk(bus.host_busy == 1'b1, "busy_after_early_vs", 64'(bus.host_busy), 64'd1);
    bus.vs_i = 1'b0;
    tick();
    frame(1'b1);

    // randomized rounds
    for (int r = 0; r < 8; r++) begin
      nw = $urandom_range(1, 12);
      wc = 1'($urandom_range(0, 1));
      for (int k = 0; k < nw; k++) begin
        idx = ($urandom_range(0, 7) == 0) ? $urandom_range(25, 31) : $urandom_range(0, 24);
        do_write(idx, $urandom, (wc && k == nw - 1));
      end
      if (!wc) do_commit(1'b0);
      if ($urandom_range(0, 1) == 1) do_write($urandom_range(0, 24), $urandom, 1'b0);
      gap = $urandom_range(0, 4);
      repeat (gap) tick();
      frame(1'($urandom_range(0, 1)));
    end

    // reset in the middle of a load
    for (int i = 0; i < 25; i++) do_write(i, $urandom, 1'b0);
    do_commit(1'b0);
    v = cyc;
    bus.vs_i = 1'b1;
    for (int i = 0; i < 25; i++) load_q.push_back('{i, model_mem[ab_m ? 0 : 1][i][15:0]});
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    check_all_zero("mid_load_reset");
    chk(cyc == v + 10, "reset_point", 64'(cyc), 64'(v + 10));
    load_q.delete();
    swap_q.delete();
    ab_m = 0; valid_m = 0; busy_m = 0;
    bus.vs_i = 1'b0;
    @(negedge clk) rst = 1'b0;
    repeat (30) tick();
    chk(bus.active_bank == 1'b0 && bus.coeff_valid == 1'b0, "after_abandon",
        {bus.active_bank, bus.coeff_valid}, 0);
    chk(swaps_seen == 12, "swap_total", 64'(swaps_seen), 64'd12);

    // normal load after the abandoned one
    do_commit(1'b0);
    frame(1'b0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coeff_bank_ctrl.md
# coeff_bank_ctrl

Double-buffered controller for the 5x5 FIR coefficient BRAM. It accepts host coefficient writes into the inactive bank of a dual-port BRAM. On a host commit it waits for the next frame start (rising edge of `vs_i`), then reads the 25 new words through port B and streams them to the coefficient register file. It finishes with a swap pulse, so the filter only changes coefficients between frames. It sits between the host register interface, `dp_bram` and `bram2coeff`'s coefficient storage.

## Interface
- `NCOEFF`, 25: coefficients per bank (5x5 kernel).
- `BANK_AW`, 5: address bits per bank; bank b occupies BRAM words b*32 .. b*32+NCOEFF-1.
- `WIDTH`, 32: BRAM word width; the coefficient is the low 16 bits, signed.

Ports:
- `clk`  in  1  single system clock, all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `host_we`  in  1  coefficient write strobe.
- `host_addr`  in  5  coefficient index 0..24 (row*5+col).
- `host_din`  in  32  coefficient word.
- `host_commit`  in  1  request to apply the inactive bank at the next frame.
- `host_busy`  out  1  commit pending or load in progress.
- `host_err`  out  1  one-cycle pulse: rejected write or commit.
- `vs_i`  in  1  vertical sync; a frame starts on its rising edge.
- `bram_we_a`  out  1  port A write enable.
- `bram_addr_a`  out  6  port A address.
- `bram_din_a`  out  32  port A data.
- `bram_addr_b`  out  6  port B read address.
- `bram_dout_b`  in  32  port B read data, 1-cycle latency.
- `coeff_we`  out  1  coefficient-file shadow write strobe.
- `coeff_idx`  out  5  shadow index.
- `coeff_data`  out  16  signed coefficient (`bram_dout_b[15:0]`).
- `coeff_swap`  out  1  one-cycle pulse: shadow becomes active.
- `active_bank`  out  1  bank currently driving the filter.
- `coeff_valid`  out  1  high once the first swap has happened.

## Operation
- **Host writes**
  - Accepted when `host_we` is high, `host_busy` is low and `host_addr` is less than 25.
  - An accepted write is registered to port A: `bram_we_a`=1, `bram_addr_a`={~`active_bank`, `host_addr`}, `bram_din_a`=`host_din`.
  - A write while busy, or with address 25..31, is dropped and `host_err` pulses.
- **Commit**
  - `host_commit` while IDLE moves the FSM to PENDING.
  - `host_commit` while busy is ignored and `host_err` pulses.
  - A commit with no prior writes is legal and reloads the bank's existing contents.
  - A write and a commit in the same cycle are both accepted.
- **Frame-start detection:** `vs_q` holds `vs_i` from the previous cycle; `vs_rise` = `vs_i` & ~`vs_q`.
- **FSM**
  - IDLE: on commit, go to PENDING.
  - PENDING: on `vs_rise`, go to READ with `rd_cnt`=0. A `vs_rise` in the same cycle as the commit does not count.
  - READ: `bram_addr_b`={~`active_bank`, `rd_cnt`}; `rd_cnt` increments each cycle. After `rd_cnt`=24 is issued, go to DRAIN.
  - DRAIN: one cycle for the last read to return, then go to SWAP.
  - SWAP: `coeff_swap`=1, `active_bank` toggles, `coeff_valid` is set, then back to IDLE.
- **Read pipeline:** `coeff_we`/`coeff_idx` are the read strobe and `rd_cnt` delayed one cycle, aligned with `bram_dout_b`.
- `vs_i` edges during READ, DRAIN or SWAP are ignored; they are never queued.
- **Port ownership:** port A is used only by host writes and port B only by the FSM, so there is no arbitration conflict.
- **Reset (asserted at any time, including mid-load)**
  - FSM returns to IDLE, `rd_cnt`=0.
  - All outputs go to 0: `active_bank`=0, `coeff_valid`=0, no swap.
  - A partially loaded shadow is abandoned.

## Timing
- Reset values: every output is 0; `vs_q`=0.
- A write accepted in cycle W appears on port A in cycle W+1.
- `host_busy` is high from the cycle after commit acceptance through the SWAP cycle inclusive, and low the following cycle. A new write or commit is accepted in that following cycle.
- Load timeline, with cycle V being the first cycle `vs_i` is sampled high while PENDING:
  - V+1: `bram_addr_b`=bank base+0.
  - V+2 .. V+26: `coeff_we`=1 with idx 0..24.
  - V+26: DRAIN cycle; `coeff_we`=1, idx 24.
  - V+27: `coeff_swap`=1; `active_bank` is toggled at the end of V+27.
  - Total 27 cycles from frame start to swap; the frame's blanking must exceed this.
- `coeff_data` is `bram_dout_b[15:0]` passed through without sign manipulation; bits 31:16 are ignored.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle -> all outputs 0 immediately, FSM IDLE.
- **Write then commit:**
  - Stimulus: write idx 0..24 with value 0x0000_0100+idx, commit, then raise `vs_i`.
  - Required: 25 `coeff_we` pulses with `coeff_data`=0x0100..0x0118; `coeff_swap` at V+27; `active_bank`=1; `coeff_valid`=1.
- **Second cycle:**
  - Stimulus: write idx 3 = 0xFFFF_FF80, commit, then `vs_i` edge.
  - Required: port A address 3 (bank 0); `coeff_data` at idx 3 = 0xFF80 (-128); `active_bank` returns to 0.
- **Rejects:**
  - Stimulus: write idx 27; write and commit while PENDING.
  - Required: `host_err` pulses each time, `bram_we_a` stays 0, state unchanged.
- **Sync edge cases:**
  - Stimulus: `vs_i` rises in the commit cycle; `vs_i` toggles during READ.
  - Required: load starts only at the next edge; exactly one load of 25 words and one swap.
- **Reset mid-load:**
  - Stimulus: assert `rst` at V+10.
  - Required: no `coeff_swap`; `active_bank`=0, `coeff_valid`=0; a subsequent commit and `vs_i` edge loads normally.
